// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited sequential fetch into a small in-order queue feeding decode.
// Optional FETCH_PERF_CNT_EN adds a saturating decode-bubble counter output.

`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

module fetch_stage #(
    parameter int ADDR = `AddrWidth,
    parameter int INST = `InstWidth,
    parameter int QDEPTH = 4,
    parameter logic [ADDR-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_,
    output logic            fetch_e_,
    output logic [ADDR-1:0] fetch_pc,
    input  logic            ic_e_,
    input  logic [ADDR-1:0] ic_pc,
    input  logic [INST-1:0] ic_inst,
    input  logic            redirect_e_,
    input  logic [ADDR-1:0] redirect_pc,
    input  logic            dec_stall,
    output logic            dec_e_,
    output logic [ADDR-1:0] dec_pc,
    output logic [INST-1:0] dec_inst
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_bubble_cnt
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    // drop can exceed QDEPTH across repeated redirects, so give it headroom
    localparam int DW = CW + 4;
    localparam logic [ADDR-1:0] STEP = ADDR'(INST / 8);
    localparam logic [ADDR-1:0] ALIGN_MASK = ~(ADDR'(INST / 8 - 1));

    logic [ADDR-1:0] pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outst;
    logic [DW-1:0]   drop;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [ADDR-1:0] q_pc   [QDEPTH];
    logic [INST-1:0] q_inst [QDEPTH];

    logic [CW:0] credit;
    logic        redirect;
    logic        resp;
    logic        resp_owed;
    logic        issue;
    logic        push;
    logic        pop;
    logic        q_valid;

    assign redirect  = !redirect_e_;
    assign resp      = !ic_e_;
    assign credit    = (CW+1)'(QDEPTH) - (CW+1)'(count) - (CW+1)'(outst);
    assign issue     = reset_ && !redirect && (credit != '0);
    assign q_valid   = (count != '0);
    // a response with nothing dropped or outstanding is a protocol error and is not owed
    assign resp_owed = resp && ((drop != '0) || (outst != '0));
    assign push      = resp && !redirect && (drop == '0) && (outst != '0);
    assign pop       = q_valid && !dec_stall && !redirect;

    assign fetch_e_  = !issue;
    assign fetch_pc  = pc;
    assign dec_e_    = !q_valid;
    assign dec_pc    = q_valid ? q_pc[rd_ptr]   : '0;
    assign dec_inst  = q_valid ? q_inst[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pc     <= RESET_PC;
            count  <= '0;
            outst  <= '0;
            drop   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (redirect) begin
            pc     <= redirect_pc & ALIGN_MASK;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            outst  <= '0;
            drop   <= drop + DW'(outst) - DW'(resp_owed);
        end else begin
            if (issue) begin
                pc <= pc + STEP;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            outst <= outst + CW'(issue) - CW'(push);
            if (resp && (drop != '0)) begin
                drop <= drop - DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= ic_pc;
            q_inst[wr_ptr] <= ic_inst;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            perf_bubble_cnt <= '0;
        end else if (dec_e_ && redirect_e_ && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
            perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: an icache model answers requests at a set latency,
// directed tests push expected decode entries, and a monitor checks every decode pop.

module tb_fetch_stage;

    logic        clk;
    logic        reset_;
    logic        fetch_e_;
    logic [31:0] fetch_pc;
    logic        ic_e_;
    logic [31:0] ic_pc;
    logic [31:0] ic_inst;
    logic        redirect_e_;
    logic [31:0] redirect_pc;
    logic        dec_stall;
    logic        dec_e_;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt;
`endif

    fetch_stage #(.ADDR(32), .INST(32), .QDEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset_      (reset_),
        .fetch_e_    (fetch_e_),
        .fetch_pc    (fetch_pc),
        .ic_e_       (ic_e_),
        .ic_pc       (ic_pc),
        .ic_inst     (ic_inst),
        .redirect_e_ (redirect_e_),
        .redirect_pc (redirect_pc),
        .dec_stall   (dec_stall),
        .dec_e_      (dec_e_),
        .dec_pc      (dec_pc),
        .dec_inst    (dec_inst)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    typedef struct {
        int          due;
        logic [31:0] pc;
    } req_t;

    req_t        pend[$];
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          lat = 1;
    int          n_req = 0;
    int          n_pass = 0;
    int          n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // icache: record requests on the falling edge
    initial begin
        req_t r;
        forever begin
            @(negedge clk);
            if (!reset_) begin
                pend.delete();
            end else if (fetch_e_ === 1'b0) begin
                r.due = cyc + lat;
                r.pc  = fetch_pc;
                pend.push_back(r);
                n_req++;
            end
        end
    end

    // icache: drive in-order responses just after the rising edge
    initial begin
        req_t r;
        ic_e_   = 1'b1;
        ic_pc   = '0;
        ic_inst = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            ic_e_   = 1'b1;
            ic_pc   = '0;
            ic_inst = '0;
            if (reset_ && pend.size() > 0 && pend[0].due == cyc) begin
                r       = pend.pop_front();
                ic_e_   = 1'b0;
                ic_pc   = r.pc;
                ic_inst = inst_of(r.pc);
            end
        end
    end

    // monitor: every accepted decode entry is compared against the scoreboard
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset_ && dec_e_ === 1'b0 && !dec_stall && redirect_e_ && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dec_pc", dec_pc, e);
                chk("dec_inst", dec_inst, inst_of(e));
            end
        end
    end

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic do_reset();
        reset_      = 1'b0;
        redirect_e_ = 1'b1;
        redirect_pc = '0;
        dec_stall   = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fetch_e", fetch_e_, 1);
        chk("rst_fetch_pc", fetch_pc, 0);
        chk("rst_dec_e", dec_e_, 1);
        chk("rst_dec_pc", dec_pc, 0);
        chk("rst_dec_inst", dec_inst, 0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        n_req  = 0;
        reset_ = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            next_cycle();
            k++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        reset_      = 1'b0;
        redirect_e_ = 1'b1;
        redirect_pc = '0;
        dec_stall   = 1'b0;

        // streaming at latency 1
        lat = 1;
        do_reset();
        push_seq(32'h0, 8);
        release_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stream_fetch_e", fetch_e_, 0);
            chk("stream_fetch_pc", fetch_pc, 32'(4 * i));
            chk("stream_dec_e", dec_e_, (i < 2) ? 1 : 0);
        end
        drain(40);

        // decode stall fills the queue, then drains in order
        lat = 1;
        do_reset();
        dec_stall = 1'b1;
        release_reset();
        repeat (10) next_cycle();
        chk("stall_nreq", n_req, 4);
        chk("stall_fetch_e", fetch_e_, 1);
        chk("stall_dec_e", dec_e_, 0);
        chk("stall_head_pc", dec_pc, 32'h0);
        push_seq(32'h0, 6);
        dec_stall = 1'b0;
        drain(40);
        chk("stall_resumed", n_req > 4, 1);

        // latency 3, redirect with two requests outstanding
        lat = 3;
        do_reset();
        push_seq(32'h1000, 3);
        release_reset();
        next_cycle();
        next_cycle();
        redirect_e_ = 1'b0;
        redirect_pc = 32'h1002;
        @(negedge clk);
        chk("rd3_fetch_blocked", fetch_e_, 1);
        next_cycle();
        redirect_e_ = 1'b1;
        for (int k = 3; k <= 7; k++) begin
            @(negedge clk);
            if (k == 3) begin
                chk("rd3_fetch_pc", fetch_pc, 32'h1000);
                chk("rd3_fetch_e", fetch_e_, 0);
            end
            chk("rd3_dec_e", dec_e_, (k < 7) ? 1 : 0);
        end
        drain(40);

        // redirect coinciding with a response while nothing is being dropped
        lat = 2;
        do_reset();
        push_seq(32'h2000, 3);
        release_reset();
        next_cycle();
        next_cycle();
        redirect_e_ = 1'b0;
        redirect_pc = 32'h2000;
        @(negedge clk);
        chk("rdr_resp_seen", ic_e_, 0);
        chk("rdr_fetch_blocked", fetch_e_, 1);
        next_cycle();
        redirect_e_ = 1'b1;
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) chk("rdr_fetch_pc", fetch_pc, 32'h2000);
            chk("rdr_dec_e", dec_e_, (k < 6) ? 1 : 0);
        end
        drain(40);

        // back-to-back redirects, drop accumulates across them
        lat = 3;
        do_reset();
        push_seq(32'h4000, 3);
        release_reset();
        next_cycle();
        redirect_e_ = 1'b0;
        redirect_pc = 32'h3000;
        next_cycle();
        redirect_e_ = 1'b1;
        @(negedge clk);
        chk("b2b_fetch_pc1", fetch_pc, 32'h3000);
        next_cycle();
        redirect_e_ = 1'b0;
        redirect_pc = 32'h4000;
        next_cycle();
        redirect_e_ = 1'b1;
        @(negedge clk);
        chk("b2b_fetch_pc2", fetch_pc, 32'h4000);
        drain(40);

        // asynchronous reset with a full queue
        lat = 1;
        do_reset();
        dec_stall = 1'b1;
        release_reset();
        repeat (8) next_cycle();
        chk("arst_full_dec_e", dec_e_, 0);
        chk("arst_full_fetch_e", fetch_e_, 1);
        #2;
        reset_ = 1'b0;
        #1;
        chk("arst_dec_e", dec_e_, 1);
        chk("arst_fetch_pc", fetch_pc, 32'h0);
        chk("arst_fetch_e", fetch_e_, 1);
        chk("arst_dec_pc", dec_pc, 32'h0);
        next_cycle();
        dec_stall = 1'b0;
        push_seq(32'h0, 4);
        release_reset();
        @(negedge clk);
        chk("arst_restart_pc", fetch_pc, 32'h0);
        chk("arst_restart_e", fetch_e_, 0);
        drain(40);

`ifdef FETCH_PERF_CNT_EN
        // bubble counter at latency 2
        lat = 2;
        do_reset();
        chk("perf_rst", perf_bubble_cnt, 0);
        push_seq(32'h0, 7);
        release_reset();
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (k == 2) chk("perf_c2", perf_bubble_cnt, 2);
            if (k == 9) chk("perf_c9", perf_bubble_cnt, 3);
        end
        drain(40);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage between the instruction cache and decode.
- Generates sequential PCs and issues one request per cycle to the icache when buffer credit allows.
- Accepts in-order icache responses into a small instruction queue and presents them to decode with a valid/stall handshake.
- On a redirect, flushes the queue and discards responses that are already in flight.

Parameters:
- ADDR, `AddrWidth (32), PC/address width.
- INST, `InstWidth (32), instruction width; PC increment = INST/8.
- QDEPTH, 4, instruction queue entries; power of two, >=2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous active-low reset
- fetch_e_  out  1  icache request strobe, active-low
- fetch_pc  out  ADDR  icache request address
- ic_e_  in  1  icache response valid, active-low
- ic_pc  in  ADDR  address of returned instruction
- ic_inst  in  INST  returned instruction
- redirect_e_  in  1  redirect request (branch/exception), active-low
- redirect_pc  in  ADDR  redirect target
- dec_stall  in  1  decode cannot accept, active-high
- dec_e_  out  1  instruction valid to decode, active-low
- dec_pc  out  ADDR  PC of presented instruction
- dec_inst  out  INST  presented instruction

Behaviour:
- Interface: single clock clk; reset_ asynchronous active-low. All state clears immediately when reset_ falls.
- Reset values:
  - pc=RESET_PC; queue empty; outst=0; drop=0.
  - fetch_e_=1; fetch_pc=RESET_PC.
  - dec_e_=1; dec_pc=0; dec_inst=0.
- Icache protocol:
  - One request per cycle where fetch_e_=0.
  - Responses return in order with latency >=1; each response is one cycle of ic_e_=0.
- Credit:
  - credit = QDEPTH - count - outst, computed from registered state only.
  - fetch_e_ = !(credit>0 && redirect_e_), combinational.
  - fetch_pc = pc.
- Issue: when fetch_e_=0, pc <= pc + INST/8 (wraps mod 2^ADDR) and outst increments.
- Response handling (ic_e_=0):
  - If drop>0: drop decrements and the data is discarded.
  - Otherwise: {ic_pc, ic_inst} is pushed at the tail and outst decrements.
  - Credit guarantees the queue never overflows. A response with drop=0 and outst=0 is a protocol error; it is ignored.
- Decode output:
  - dec_e_=0 iff the queue is non-empty; dec_pc/dec_inst show the head entry.
  - When the queue is empty, dec_pc/dec_inst are 0.
  - Pop occurs when dec_e_=0 && !dec_stall. Push and pop may happen in the same cycle, including when full (count unchanged).
  - Zero-latency bypass is not provided: a pushed entry is visible the cycle after ic_e_.
- Redirect (redirect_e_=0), at the clock edge:
  - Queue flushed (count=0, pointers reset).
  - pc <= redirect_pc with the low log2(INST/8) bits forced to 0.
  - No request issued that cycle.
  - drop <= drop + outst - (response this cycle ? 1 : 0); outst <= 0.
  - Any response arriving in the redirect cycle is discarded; any pop in that cycle is ignored.
  - dec_e_=1 from the next cycle.
- Back-to-back redirects: the last one wins; drop accumulates correctly.
- Reset mid-operation: returns to the reset state. In-flight responses arriving after reset are treated as protocol errors and ignored (the icache is reset together with this block).
- Ordering: queue entries preserve icache return order. dec_pc increases by INST/8 between consecutive entries unless a redirect intervenes.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined: adds output perf_bubble_cnt (32 bits, reset 0).
  - Increments each cycle with dec_e_=1 && redirect_e_=1.
  - Saturates at 0xFFFFFFFF.
  - Not cleared by redirect.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, icache latency 1, dec_stall=0 -> fetch_pc 0x0,0x4,0x8... on consecutive cycles; dec_e_ first low 2 cycles after first request; dec_pc sequence 0x0,0x4,0x8 with no gaps.
- Hold dec_stall=1 with latency 1 -> exactly 4 requests issued (0x0–0xC), then fetch_e_=1; queue holds 4 entries; releasing the stall drains 0x0..0xC in order and issuing resumes.
- Latency 3, redirect to 0x1002 when outst=2 -> next fetch_pc=0x1000; the two stale responses are discarded; first dec_pc after redirect =0x1000.
- Redirect in the same cycle as a response with drop=0 -> response discarded; drop = outst-1; no stale instruction reaches decode.
- Assert reset_ low mid-stream with a full queue -> dec_e_=1 and fetch_pc=RESET_PC asynchronously; fetching restarts at RESET_PC after release.
- FETCH_PERF_CNT_EN defined, latency 2, 10 cycles starting from reset -> perf_bubble_cnt counts the initial empty cycles (3), then holds while the stream is valid.
